fx_bus_master: RTL and testbench

Upstream master for the fx register bus. It turns a host byte stream (UART/FX2 receive side) into single-cycle fx bus write and read strobes. It drives the shared fx_waddr/fx_raddr/fx_data/fx_wr/fx_rd lines seen by every register slave (commu_reg and peers). For reads, it captures the OR'ed fx_q return and sends it back as one response byte on a valid/ready transmit interface.

---
 rtl/fx_bus_pkg.sv | 37 +++
 rtl/fx_bus_master_if.sv | 29 ++
 rtl/fx_bus_master.sv | 183 ++++++++++++++++++
 tb/tb_fx_bus_master.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_bus_pkg.sv
// Shared definitions for the fx register bus master: FSM encoding, command bytes,
// bus widths and address field positions.
package fx_bus_pkg;

    localparam int unsigned FX_ADDR_W = 16;
    localparam int unsigned FX_DATA_W = 8;
    localparam int unsigned FX_TO_W   = 24;

    // fx address layout: module id in [13:8], register offset in [7:0]
    localparam int unsigned FX_MOD_ID_MSB = 13;
    localparam int unsigned FX_MOD_ID_LSB = 8;
    localparam int unsigned FX_REG_MSB    = 7;
    localparam int unsigned FX_REG_LSB    = 0;

    localparam logic [FX_DATA_W-1:0] CMD_WR_DEF      = 8'h57;
    localparam logic [FX_DATA_W-1:0] CMD_RD_DEF      = 8'h52;
    localparam logic [FX_TO_W-1:0]   TIMEOUT_CYC_DEF = 24'd5_000_000;
    localparam int unsigned          RD_LAT_DEF      = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR_H = 3'd1,
        ST_ADDR_L = 3'd2,
        ST_DATA   = 3'd3,
        ST_DO_WR  = 3'd4,
        ST_DO_RD  = 3'd5,
        ST_WAIT_Q = 3'd6,
        ST_SEND   = 3'd7
    } fx_state_t;

    // Address bytes arrive MSB first
    function automatic logic [FX_ADDR_W-1:0] fx_addr(input logic [FX_DATA_W-1:0] hi,
                                                     input logic [FX_DATA_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/fx_bus_master_if.sv
// Host byte stream, response stream and shared fx register bus lines of the bus master.
interface fx_bus_master_if;
    import fx_bus_pkg::*;

    logic [FX_DATA_W-1:0] rx_data;
    logic                 rx_vld;
    logic [FX_DATA_W-1:0] tx_data;
    logic                 tx_vld;
    logic                 tx_rdy;
    logic [FX_ADDR_W-1:0] fx_waddr;
    logic                 fx_wr;
    logic [FX_DATA_W-1:0] fx_data;
    logic                 fx_rd;
    logic [FX_ADDR_W-1:0] fx_raddr;
    logic [FX_DATA_W-1:0] fx_q;
    logic                 err;
    logic                 busy;

    modport master (
        input  rx_data, rx_vld, tx_rdy, fx_q,
        output tx_data, tx_vld, fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr, err, busy
    );

    modport slave (
        output rx_data, rx_vld, tx_rdy, fx_q,
        input  tx_data, tx_vld, fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr, err, busy
    );

endinterface

// File: rtl/fx_bus_master.sv
// Host-packet to fx register bus bridge: decodes write/read packets into single-cycle
// strobes and returns read data as one response byte.
module fx_bus_master
    import fx_bus_pkg::*;
#(
    parameter logic [FX_TO_W-1:0]   TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned          RD_LAT      = RD_LAT_DEF,
    parameter logic [FX_DATA_W-1:0] CMD_WR      = CMD_WR_DEF,
    parameter logic [FX_DATA_W-1:0] CMD_RD      = CMD_RD_DEF
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    fx_bus_master_if.master   bus
);

    localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    fx_state_t            state_q,    state_d;
    logic                 is_rd_q,    is_rd_d;
    logic [FX_DATA_W-1:0] addr_hi_q,  addr_hi_d;
    logic [FX_DATA_W-1:0] addr_lo_q,  addr_lo_d;
    logic [FX_TO_W-1:0]   to_cnt_q,   to_cnt_d;
    logic [LAT_W-1:0]     lat_q,      lat_d;
    logic [FX_ADDR_W-1:0] fx_waddr_q, fx_waddr_d;
    logic [FX_ADDR_W-1:0] fx_raddr_q, fx_raddr_d;
    logic [FX_DATA_W-1:0] fx_data_q,  fx_data_d;
    logic                 fx_wr_q,    fx_wr_d;
    logic                 fx_rd_q,    fx_rd_d;
    logic [FX_DATA_W-1:0] tx_data_q,  tx_data_d;
    logic                 tx_vld_q,   tx_vld_d;
    logic                 err_q,      err_d;
    logic                 busy_q,     busy_d;

    logic pkt_phase_c;
    logic expired_c;

    assign pkt_phase_c = (state_q == ST_ADDR_H) || (state_q == ST_ADDR_L) || (state_q == ST_DATA);
    assign expired_c   = (to_cnt_q == (TIMEOUT_CYC - FX_TO_W'(1)));

    // Next-state and next-output decode
    always_comb begin
        state_d    = state_q;
        is_rd_d    = is_rd_q;
        addr_hi_d  = addr_hi_q;
        addr_lo_d  = addr_lo_q;
        to_cnt_d   = '0;
        lat_d      = lat_q;
        fx_waddr_d = fx_waddr_q;
        fx_raddr_d = fx_raddr_q;
        fx_data_d  = fx_data_q;
        fx_wr_d    = 1'b0;
        fx_rd_d    = 1'b0;
        tx_data_d  = tx_data_q;
        tx_vld_d   = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_vld) begin
                    if ((bus.rx_data == CMD_WR) || (bus.rx_data == CMD_RD)) begin
                        state_d = ST_ADDR_H;
                        is_rd_d = (bus.rx_data == CMD_RD);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ADDR_H: begin
                if (bus.rx_vld) begin
                    addr_hi_d = bus.rx_data;
                    state_d   = ST_ADDR_L;
                end
            end
            ST_ADDR_L: begin
                if (bus.rx_vld) begin
                    addr_lo_d = bus.rx_data;
                    if (is_rd_q) begin
                        state_d    = ST_DO_RD;
                        fx_rd_d    = 1'b1;
                        fx_raddr_d = fx_addr(addr_hi_q, bus.rx_data);
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (bus.rx_vld) begin
                    state_d    = ST_DO_WR;
                    fx_wr_d    = 1'b1;
                    fx_data_d  = bus.rx_data;
                    fx_waddr_d = fx_addr(addr_hi_q, addr_lo_q);
                end
            end
            ST_DO_WR: begin
                err_d   = bus.rx_vld;
                state_d = ST_IDLE;
            end
            ST_DO_RD: begin
                err_d   = bus.rx_vld;
                lat_d   = '0;
                state_d = ST_WAIT_Q;
            end
            ST_WAIT_Q: begin
                err_d = bus.rx_vld;
                if (lat_q == LAT_W'(RD_LAT - 1)) begin
                    tx_data_d = bus.fx_q;
                    tx_vld_d  = 1'b1;
                    state_d   = ST_SEND;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_SEND: begin
                err_d = bus.rx_vld;
                if (bus.tx_rdy) begin
                    state_d = ST_IDLE;
                end else begin
                    tx_vld_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Inter-byte timeout; a byte arriving on the expiry cycle takes priority
        if (pkt_phase_c && !bus.rx_vld) begin
            if (expired_c) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + FX_TO_W'(1);
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            is_rd_q    <= 1'b0;
            addr_hi_q  <= '0;
            addr_lo_q  <= '0;
            to_cnt_q   <= '0;
            lat_q      <= '0;
            fx_waddr_q <= '0;
            fx_raddr_q <= '0;
            fx_data_q  <= '0;
            fx_wr_q    <= 1'b0;
            fx_rd_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_vld_q   <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_rd_q    <= is_rd_d;
            addr_hi_q  <= addr_hi_d;
            addr_lo_q  <= addr_lo_d;
            to_cnt_q   <= to_cnt_d;
            lat_q      <= lat_d;
            fx_waddr_q <= fx_waddr_d;
            fx_raddr_q <= fx_raddr_d;
            fx_data_q  <= fx_data_d;
            fx_wr_q    <= fx_wr_d;
            fx_rd_q    <= fx_rd_d;
            tx_data_q  <= tx_data_d;
            tx_vld_q   <= tx_vld_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.fx_waddr = fx_waddr_q;
    assign bus.fx_raddr = fx_raddr_q;
    assign bus.fx_data  = fx_data_q;
    assign bus.fx_wr    = fx_wr_q;
    assign bus.fx_rd    = fx_rd_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_vld   = tx_vld_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_fx_bus_master.sv
// Bench for fx_bus_master: random packets against an expected register image,
// with a registered slave model answering reads one cycle after fx_rd.
module tb_fx_bus_master;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    fx_bus_master_if bus ();

    fx_bus_master #(
        .TIMEOUT_CYC (24'd16),
        .RD_LAT      (1),
        .CMD_WR      (8'h57),
        .CMD_RD      (8'h52)
    ) dut (
        .clk_sys (clk),
        .rst_n   (rst_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register slave: stores writes, returns read data registered one cycle after fx_rd
    logic [7:0]  slv_mem [0:65535];
    logic [7:0]  slv_q;
    logic [7:0]  exp_mem [0:65535];
    logic [15:0] wr_addrs [$];
    logic        both_seen;
    int          wr_cnt;

    assign bus.fx_q = slv_q;

    always @(posedge clk) begin
        if (bus.fx_wr) slv_mem[bus.fx_waddr] <= bus.fx_data;
        slv_q <= bus.fx_rd ? slv_mem[bus.fx_raddr] : 8'h00;
        if (bus.fx_wr && bus.fx_rd) both_seen <= 1'b1;
        if (bus.fx_wr) wr_cnt <= wr_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_vld  = 1'b1;
        tick();
        bus.rx_vld  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.tx_vld   !== 1'b0)  begin errors++; $display("FAIL rst_tx_vld got=%b exp=0", bus.tx_vld); end
        checks++; if (bus.tx_data  !== 8'h00) begin errors++; $display("FAIL rst_tx_data got=%h exp=00", bus.tx_data); end
        checks++; if (bus.fx_wr    !== 1'b0)  begin errors++; $display("FAIL rst_fx_wr got=%b exp=0", bus.fx_wr); end
        checks++; if (bus.fx_rd    !== 1'b0)  begin errors++; $display("FAIL rst_fx_rd got=%b exp=0", bus.fx_rd); end
        checks++; if (bus.fx_waddr !== 16'h0) begin errors++; $display("FAIL rst_fx_waddr got=%h exp=0000", bus.fx_waddr); end
        checks++; if (bus.fx_raddr !== 16'h0) begin errors++; $display("FAIL rst_fx_raddr got=%h exp=0000", bus.fx_raddr); end
        checks++; if (bus.fx_data  !== 8'h00) begin errors++; $display("FAIL rst_fx_data got=%h exp=00", bus.fx_data); end
        checks++; if (bus.err      !== 1'b0)  begin errors++; $display("FAIL rst_err got=%b exp=0", bus.err); end
        checks++; if (bus.busy     !== 1'b0)  begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_write();
        for (int i = 0; i < 6; i++) begin
            logic [15:0] a;
            logic [7:0]  d;
            a = (i == 0) ? 16'h0510 : 16'($urandom);
            d = (i == 0) ? 8'h14    : 8'($urandom);
            send(8'h57); send(a[15:8]); send(a[7:0]);
            checks++; if (bus.fx_wr !== 1'b0) begin errors++; $display("FAIL wr_early got=%b exp=0", bus.fx_wr); end
            send(d);
            checks++; if (bus.fx_wr    !== 1'b1) begin errors++; $display("FAIL wr_strobe got=%b exp=1", bus.fx_wr); end
            checks++; if (bus.fx_waddr !== a)    begin errors++; $display("FAIL wr_addr got=%h exp=%h", bus.fx_waddr, a); end
            checks++; if (bus.fx_data  !== d)    begin errors++; $display("FAIL wr_data got=%h exp=%h", bus.fx_data, d); end
            checks++; if (bus.fx_rd | bus.tx_vld | bus.err) begin errors++; $display("FAIL wr_side rd=%b tx_vld=%b err=%b exp=000", bus.fx_rd, bus.tx_vld, bus.err); end
            exp_mem[a] = d;
            wr_addrs.push_back(a);
            tick();
            checks++; if (bus.fx_wr    !== 1'b0) begin errors++; $display("FAIL wr_one_cycle got=%b exp=0", bus.fx_wr); end
            checks++; if (bus.busy     !== 1'b0) begin errors++; $display("FAIL wr_idle_busy got=%b exp=0", bus.busy); end
            checks++; if (bus.fx_waddr !== a)    begin errors++; $display("FAIL wr_addr_hold got=%h exp=%h", bus.fx_waddr, a); end
        end
    endtask

    task automatic test_read();
        bus.tx_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [15:0] a;
            if (i == 0)          a = 16'h0510;
            else if (i % 2 == 1) a = 16'($urandom);
            else                 a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
            send(8'h52); send(a[15:8]); send(a[7:0]);
            checks++; if (bus.fx_rd    !== 1'b1) begin errors++; $display("FAIL rd_strobe got=%b exp=1", bus.fx_rd); end
            checks++; if (bus.fx_raddr !== a)    begin errors++; $display("FAIL rd_addr got=%h exp=%h", bus.fx_raddr, a); end
            checks++; if (bus.fx_wr    !== 1'b0) begin errors++; $display("FAIL rd_no_wr got=%b exp=0", bus.fx_wr); end
            tick();
            checks++; if ({bus.fx_rd, bus.tx_vld} !== 2'b00) begin errors++; $display("FAIL rd_wait rd/tx_vld got=%b exp=00", {bus.fx_rd, bus.tx_vld}); end
            tick();
            checks++; if (bus.tx_vld  !== 1'b1)       begin errors++; $display("FAIL rd_tx_vld got=%b exp=1", bus.tx_vld); end
            checks++; if (bus.tx_data !== exp_mem[a]) begin errors++; $display("FAIL rd_tx_data addr=%h got=%h exp=%h", a, bus.tx_data, exp_mem[a]); end
            tick();
            checks++; if ({bus.tx_vld, bus.busy} !== 2'b00) begin errors++; $display("FAIL rd_done tx_vld/busy got=%b exp=00", {bus.tx_vld, bus.busy}); end
        end
    endtask

    task automatic test_backpressure();
        send(8'h57); send(8'h05); send(8'h00); send(8'h05);
        exp_mem[16'h0500] = 8'h05;
        tick();
        bus.tx_rdy = 1'b0;
        send(8'h52); send(8'h05); send(8'h00);
        tick(); tick();
        for (int k = 0; k < 20; k++) begin
            checks++; if (bus.tx_vld  !== 1'b1)                begin errors++; $display("FAIL bp_hold_vld cyc=%0d got=%b exp=1", k, bus.tx_vld); end
            checks++; if (bus.tx_data !== exp_mem[16'h0500])   begin errors++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=%h", k, bus.tx_data, exp_mem[16'h0500]); end
            if (k == 6) begin
                checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL bp_overrun_err got=%b exp=1", bus.err); end
            end
            if (k == 5) send(8'h57);
            else        tick();
        end
        checks++; if (bus.tx_vld !== 1'b1) begin errors++; $display("FAIL bp_vld_before_accept got=%b exp=1", bus.tx_vld); end
        bus.tx_rdy = 1'b1;
        tick();
        checks++; if ({bus.tx_vld, bus.busy, bus.err} !== 3'b000) begin errors++; $display("FAIL bp_accept vld/busy/err got=%b exp=000", {bus.tx_vld, bus.busy, bus.err}); end
    endtask

    task automatic test_bad_cmd_timeout();
        int cyc;
        int wr0;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] b;
            b = (i == 0) ? 8'h00 : 8'($urandom);
            if (b == 8'h57 || b == 8'h52) b = 8'h00;
            send(b);
            checks++; if ({bus.err, bus.busy} !== 2'b10) begin errors++; $display("FAIL badcmd err/busy byte=%h got=%b exp=10", b, {bus.err, bus.busy}); end
            tick();
            checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL badcmd_pulse got=%b exp=0", bus.err); end
        end
        wr0 = wr_cnt;
        send(8'h57); send(8'h05);
        cyc = 1;
        while (bus.err !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        checks++; if (cyc !== 17)       begin errors++; $display("FAIL timeout_cycle got=%0d exp=17", cyc); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%b exp=0", bus.busy); end
        checks++; if (wr_cnt !== wr0)    begin errors++; $display("FAIL timeout_no_wr got=%0d exp=%0d", wr_cnt, wr0); end
        send(8'h57); send(8'h05); send(8'h80); send(8'hAA);
        checks++; if ({bus.fx_wr, bus.fx_waddr, bus.fx_data} !== {1'b1, 16'h0580, 8'hAA}) begin errors++; $display("FAIL post_timeout_wr got=%b/%h/%h exp=1/0580/aa", bus.fx_wr, bus.fx_waddr, bus.fx_data); end
        exp_mem[16'h0580] = 8'hAA;
        tick();
        // byte landing on the expiry cycle must be accepted
        send(8'h57);
        repeat (15) tick();
        send(8'h05);
        checks++; if ({bus.err, bus.busy} !== 2'b01) begin errors++; $display("FAIL expiry_byte_wins err/busy got=%b exp=01", {bus.err, bus.busy}); end
        send(8'h81); send(8'hBB);
        checks++; if ({bus.fx_wr, bus.fx_waddr, bus.fx_data} !== {1'b1, 16'h0581, 8'hBB}) begin errors++; $display("FAIL expiry_wr got=%b/%h/%h exp=1/0581/bb", bus.fx_wr, bus.fx_waddr, bus.fx_data); end
        exp_mem[16'h0581] = 8'hBB;
        tick();
    endtask

    task automatic test_back_to_back();
        bus.tx_rdy = 1'b1;
        both_seen  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] a;
            logic [7:0]  d;
            a = (i == 0) ? 16'h0510 : 16'($urandom);
            d = (i == 0) ? 8'h20    : 8'($urandom);
            send(8'h57); send(a[15:8]); send(a[7:0]); send(d);
            checks++; if (bus.fx_wr !== 1'b1) begin errors++; $display("FAIL b2b_wr got=%b exp=1", bus.fx_wr); end
            exp_mem[a] = d;
            tick();
            send(8'h52); send(a[15:8]); send(a[7:0]);
            checks++; if ({bus.fx_rd, bus.fx_wr, bus.fx_raddr} !== {2'b10, a}) begin errors++; $display("FAIL b2b_rd got=%b%b/%h exp=10/%h", bus.fx_rd, bus.fx_wr, bus.fx_raddr, a); end
            tick(); tick();
            checks++; if ({bus.tx_vld, bus.tx_data} !== {1'b1, d}) begin errors++; $display("FAIL b2b_resp got=%b/%h exp=1/%h", bus.tx_vld, bus.tx_data, d); end
            tick();
        end
        checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL b2b_wr_rd_overlap got=%b exp=0", both_seen); end
    endtask

    task automatic test_reset_mid();
        bus.tx_rdy = 1'b1;
        send(8'h52); send(8'h05); send(8'h10);
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.tx_vld, bus.fx_rd, bus.fx_wr, bus.busy} !== 4'b0000) begin errors++; $display("FAIL rst_waitq vld/rd/wr/busy got=%b exp=0000", {bus.tx_vld, bus.fx_rd, bus.fx_wr, bus.busy}); end
        checks++; if (bus.fx_raddr !== 16'h0) begin errors++; $display("FAIL rst_waitq_raddr got=%h exp=0000", bus.fx_raddr); end
        tick();
        rst_n = 1'b1;
        tick();
        bus.tx_rdy = 1'b0;
        send(8'h52); send(8'h05); send(8'h10);
        tick(); tick();
        checks++; if (bus.tx_vld !== 1'b1) begin errors++; $display("FAIL pre_rst_send_vld got=%b exp=1", bus.tx_vld); end
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.tx_vld, bus.busy} !== 2'b00) begin errors++; $display("FAIL rst_send vld/busy got=%b exp=00", {bus.tx_vld, bus.busy}); end
        tick();
        rst_n = 1'b1;
        bus.tx_rdy = 1'b1;
        tick();
        send(8'h52); send(8'h05); send(8'h10);
        tick(); tick();
        checks++; if ({bus.tx_vld, bus.tx_data} !== {1'b1, exp_mem[16'h0510]}) begin errors++; $display("FAIL post_rst_read got=%b/%h exp=1/%h", bus.tx_vld, bus.tx_data, exp_mem[16'h0510]); end
        tick();
        checks++; if ({bus.tx_vld, bus.busy} !== 2'b00) begin errors++; $display("FAIL post_rst_idle got=%b exp=00", {bus.tx_vld, bus.busy}); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        errors      = 0;
        checks      = 0;
        wr_cnt      = 0;
        both_seen   = 1'b0;
        rst_n       = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_vld  = 1'b0;
        bus.tx_rdy  = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            slv_mem[i] = 8'h00;
            exp_mem[i] = 8'h00;
        end
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_bad_cmd_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
